// File: rtl/btn_debounce_pulse.sv
// Push-button conditioner: synchronizer, counter debounce, edge pulses
// and press-and-hold auto-repeat feeding the control FSM's x input.
module btn_debounce_pulse #(
  parameter int CNT_MAX    = 2000000,
  parameter int REP_DELAY  = 50000000,
  parameter int REP_PERIOD = 10000000,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic level,
  output logic press_pulse,
  output logic release_pulse,
  output logic rep_pulse
);

  localparam int HMAX = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
  localparam int DW   = $clog2(CNT_MAX);
  localparam int HW   = $clog2(HMAX);

  localparam logic [DW-1:0] D_LAST = DW'(CNT_MAX - 1);
  localparam logic [HW-1:0] H_DLY  = HW'(REP_DELAY - 1);
  localparam logic [HW-1:0] H_PER  = HW'(REP_PERIOD - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DELAY,
    S_REPEAT
  } state_t;

  logic          r_s1;
  logic          r_s2;
  logic          r_level;
  logic [DW-1:0] r_dcnt;
  logic          r_press;
  logic          r_rel;
  logic          r_rep;
  logic [HW-1:0] r_hcnt;
  state_t        r_state;

  logic          w_b;
  logic          w_diff;
  logic          w_flip;
  logic          w_press;
  logic          w_rel;
  state_t        w_state_n;
  logic [HW-1:0] w_hcnt_n;
  logic          w_rep_n;

  assign w_b     = btn_raw ^ ACTIVE_LOW;
  assign w_diff  = r_s2 ^ r_level;
  assign w_flip  = w_diff && (r_dcnt == D_LAST);
  assign w_press = w_flip && r_s2;
  assign w_rel   = w_flip && !r_s2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_level <= 1'b0;
      r_dcnt  <= '0;
      r_press <= 1'b0;
      r_rel   <= 1'b0;
    end else begin
      r_s1    <= w_b;
      r_s2    <= r_s1;
      r_press <= w_press;
      r_rel   <= w_rel;
      if (!w_diff) begin
        r_dcnt <= '0;
      end else if (w_flip) begin
        r_dcnt  <= '0;
        r_level <= r_s2;
      end else begin
        r_dcnt <= r_dcnt + DW'(1);
      end
    end
  end

  // Release overrides any repeat that falls due on the same edge
  always_comb begin
    w_state_n = r_state;
    w_hcnt_n  = r_hcnt;
    w_rep_n   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_press) begin
          w_state_n = S_DELAY;
          w_hcnt_n  = '0;
        end
      end
      S_DELAY: begin
        if (r_hcnt == H_DLY) begin
          w_rep_n   = 1'b1;
          w_hcnt_n  = '0;
          w_state_n = S_REPEAT;
        end else begin
          w_hcnt_n = r_hcnt + HW'(1);
        end
      end
      S_REPEAT: begin
        if (r_hcnt == H_PER) begin
          w_rep_n  = 1'b1;
          w_hcnt_n = '0;
        end else begin
          w_hcnt_n = r_hcnt + HW'(1);
        end
      end
      default: begin
        w_state_n = S_IDLE;
        w_hcnt_n  = '0;
      end
    endcase
    if (w_rel) begin
      w_state_n = S_IDLE;
      w_hcnt_n  = '0;
      w_rep_n   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_hcnt  <= '0;
      r_rep   <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_hcnt  <= w_hcnt_n;
      r_rep   <= w_rep_n;
    end
  end

  assign level         = r_level;
  assign press_pulse   = r_press;
  assign release_pulse = r_rel;
  assign rep_pulse     = r_rep;

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// Bench for btn_debounce_pulse: directed timing steps plus random
// button traffic against a run-length/elapsed-time reference model.
module tb_btn_debounce_pulse;

  localparam int CM = 4;
  localparam int RD = 10;
  localparam int RP = 5;

  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic btn0 = 1'b0;
  logic btn1 = 1'b1;

  logic lvl0, prs0, rel0, rep0;
  logic lvl1, prs1, rel1, rep1;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  bit m_lvl [2];
  bit m_prs [2];
  bit m_rel [2];
  bit m_rep [2];
  bit hs    [2][3];
  int run   [2];
  int since [2];

  always #5 clk = ~clk;

  btn_debounce_pulse #(
    .CNT_MAX(CM), .REP_DELAY(RD), .REP_PERIOD(RP), .ACTIVE_LOW(1'b0)
  ) u_dut0 (
    .clk(clk), .rst(rst), .btn_raw(btn0),
    .level(lvl0), .press_pulse(prs0),
    .release_pulse(rel0), .rep_pulse(rep0)
  );

  btn_debounce_pulse #(
    .CNT_MAX(CM), .REP_DELAY(RD), .REP_PERIOD(RP), .ACTIVE_LOW(1'b1)
  ) u_dut1 (
    .clk(clk), .rst(rst), .btn_raw(btn1),
    .level(lvl1), .press_pulse(prs1),
    .release_pulse(rel1), .rep_pulse(rep1)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
    end
  endtask

  task model_reset();
    for (int i = 0; i < 2; i++) begin
      m_lvl[i] = 1'b0;
      m_prs[i] = 1'b0;
      m_rel[i] = 1'b0;
      m_rep[i] = 1'b0;
      for (int j = 0; j < 3; j++) hs[i][j] = 1'b0;
      run[i]   = 0;
      since[i] = 0;
    end
  endtask

  // Level flips after CM consecutive disagreeing samples; repeats are
  // timed from the press edge by elapsed cycle count.
  task model_edge();
    bit b [2];
    bit c;
    b[0] = btn0;
    b[1] = ~btn1;
    for (int i = 0; i < 2; i++) begin
      hs[i][2] = hs[i][1];
      hs[i][1] = hs[i][0];
      hs[i][0] = b[i];
      c = hs[i][2];
      m_prs[i] = 1'b0;
      m_rel[i] = 1'b0;
      m_rep[i] = 1'b0;
      run[i] = (c != m_lvl[i]) ? run[i] + 1 : 0;
      if (run[i] == CM) begin
        run[i]   = 0;
        m_lvl[i] = c;
        if (c) begin
          m_prs[i] = 1'b1;
          since[i] = 0;
        end else begin
          m_rel[i] = 1'b1;
        end
      end else if (m_lvl[i]) begin
        since[i]++;
        if (since[i] == RD ||
            (since[i] > RD && (since[i] - RD) % RP == 0))
          m_rep[i] = 1'b1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else model_edge();
    @(negedge clk);
    cyc++;
    chk("lvl0", lvl0, m_lvl[0]);
    chk("prs0", prs0, m_prs[0]);
    chk("rel0", rel0, m_rel[0]);
    chk("rep0", rep0, m_rep[0]);
    chk("lvl1", lvl1, m_lvl[1]);
    chk("prs1", prs1, m_prs[1]);
    chk("rel1", rel1, m_rel[1]);
    chk("rep1", rep1, m_rep[1]);
  endtask

  initial begin
    model_reset();
    repeat (3) tick();
    rst = 1'b0;
    repeat (5) tick();

    // press latency
    btn0 = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk("t1_pre_lvl", lvl0, 1'b0);
      chk("t1_pre_prs", prs0, 1'b0);
      chk("t1_pre_rep", rep0, 1'b0);
    end
    tick();
    chk("t1_lvl", lvl0, 1'b1);
    chk("t1_prs", prs0, 1'b1);

    // repeats at P+10, +15, +20, +25, +30
    for (int k = 1; k <= 26; k++) begin
      tick();
      chk("t1_prs_once", prs0, 1'b0);
      chk("t1_rep", rep0, (k >= RD && (k - RD) % RP == 0));
    end
    btn0 = 1'b0;
    for (int k = 27; k <= 31; k++) begin
      tick();
      chk("t1_hold_lvl", lvl0, 1'b1);
      chk("t1_hold_rep", rep0, (k == 30));
      chk("t1_hold_rel", rel0, 1'b0);
    end
    tick();
    chk("t1_rel", rel0, 1'b1);
    chk("t1_rel_lvl", lvl0, 1'b0);
    chk("t1_rel_rep", rep0, 1'b0);
    repeat (20) begin
      tick();
      chk("t1_post_rep", rep0, 1'b0);
      chk("t1_post_rel", rel0, 1'b0);
    end

    // bounce rejection
    for (int k = 0; k < 20; k++) begin
      btn0 = (k < 6) && ((k / 2) % 2 == 0);
      tick();
      chk("t2_lvl", lvl0, 1'b0);
      chk("t2_prs", prs0, 1'b0);
      chk("t2_rel", rel0, 1'b0);
    end

    // release coinciding with the P+15 repeat
    btn0 = 1'b1;
    repeat (5) tick();
    tick();
    chk("t3_prs", prs0, 1'b1);
    repeat (9) tick();
    btn0 = 1'b0;
    tick();
    chk("t3_rep10", rep0, 1'b1);
    repeat (4) tick();
    tick();
    chk("t3_rel", rel0, 1'b1);
    chk("t3_rep", rep0, 1'b0);
    chk("t3_lvl", lvl0, 1'b0);
    repeat (10) tick();

    // asynchronous reset mid-hold
    btn0 = 1'b1;
    repeat (6) tick();
    chk("t4_prs", prs0, 1'b1);
    repeat (12) tick();
    chk("t4_pre_lvl", lvl0, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("t4_rst_lvl", lvl0, 1'b0);
    chk("t4_rst_prs", prs0, 1'b0);
    chk("t4_rst_rel", rel0, 1'b0);
    chk("t4_rst_rep", rep0, 1'b0);
    tick();
    rst = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk("t4_re_lvl", lvl0, 1'b0);
      chk("t4_re_prs", prs0, 1'b0);
    end
    tick();
    chk("t4_re_press", prs0, 1'b1);
    chk("t4_re_level", lvl0, 1'b1);
    btn0 = 1'b0;
    repeat (10) tick();

    // random traffic on both instances
    for (int k = 0; k < 80; k++) begin
      btn0 = 1'($urandom_range(0, 1));
      btn1 = 1'($urandom_range(0, 1));
      repeat ($urandom_range(1, 14)) tick();
    end
    btn0 = 1'b0;
    btn1 = 1'b1;
    repeat (20) tick();

    // active-low instance
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t6_idle_lvl", lvl1, 1'b0);
      chk("t6_idle_prs", prs1, 1'b0);
    end
    btn1 = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk("t6_pre_lvl", lvl1, 1'b0);
    end
    tick();
    chk("t6_prs", prs1, 1'b1);
    chk("t6_lvl", lvl1, 1'b1);
    tick();
    chk("t6_prs_once", prs1, 1'b0);
    btn1 = 1'b1;
    repeat (10) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/btn_debounce_pulse.md
Name: btn_debounce_pulse

Overview:
- Conditions a raw board push-button into a clean level and single-cycle event pulses.
- Sits directly upstream of the two-state Moore control FSM; its debounced level drives that FSM's x input.
- Chain: 2-flop synchronizer, counter-based debounce, edge detection, press-and-hold auto-repeat.

Parameters:
CNT_MAX, 2000000, consecutive stable cycles required to accept a level change (20 ms at 100 MHz); must be >=2
REP_DELAY, 50000000, cycles from press_pulse to first rep_pulse; must be >=2
REP_PERIOD, 10000000, cycles between subsequent rep_pulse; must be >=2
ACTIVE_LOW, 0, 1 = raw button reads 0 when pressed; input inverted before synchronizer

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
btn_raw  input  1  raw asynchronous button pin
level  output  1  debounced pressed level (1 = pressed); feeds FSM x
press_pulse  output  1  one-cycle pulse on accepted press
release_pulse  output  1  one-cycle pulse on accepted release
rep_pulse  output  1  one-cycle auto-repeat pulse while held

Behaviour:
- Reset is rst, asynchronous, active-high; clock is clk, rising edge.
- On rst: sync flops, level, press_pulse, release_pulse, rep_pulse = 0; all counters = 0. Applies immediately, including mid-debounce or mid-hold.
- Input prep: b = btn_raw XOR ACTIVE_LOW.
- Synchronizer: s1 <= b; s2 <= s1. Only s2 is used downstream.
- Debounce counter dcnt, width $clog2(CNT_MAX):
  - s2 == level: dcnt <= 0.
  - s2 != level and dcnt < CNT_MAX-1: dcnt <= dcnt+1.
  - s2 != level and dcnt == CNT_MAX-1: level <= s2; dcnt <= 0.
- Latency: raw change held stable flips level on the (CNT_MAX+2)th rising edge, counting the first edge that samples the new raw value.
- Glitch rejection: any s2 mismatch shorter than CNT_MAX cycles restarts dcnt and leaves level unchanged.
- Pulses are registered and asserted on the same edge level changes, for exactly one cycle:
  - press_pulse on a 0->1 level change.
  - release_pulse on a 1->0 level change.
  - press_pulse and release_pulse are never high together.
- Hold state machine, registered:
  - States: IDLE, HOLD_DELAY, HOLD_REPEAT.
  - IDLE -> HOLD_DELAY on press (hcnt <= 0).
  - HOLD_DELAY: hcnt increments each cycle. When hcnt == REP_DELAY-1: rep_pulse <= 1, hcnt <= 0, go to HOLD_REPEAT.
  - HOLD_REPEAT: hcnt increments. When hcnt == REP_PERIOD-1: rep_pulse <= 1, hcnt <= 0.
  - First rep_pulse is exactly REP_DELAY cycles after press_pulse; later ones every REP_PERIOD cycles.
  - hcnt width: $clog2(max(REP_DELAY, REP_PERIOD)).
  - Any state -> IDLE on release, hcnt <= 0.
  - If release and a due repeat fall on the same edge, release wins: release_pulse=1, rep_pulse=0.
- rep_pulse is never asserted in IDLE, and never on the same cycle as press_pulse.
- Counter arithmetic is unsigned and never wraps; each counter clears at its terminal value.

Test Plan:
- Sim params CNT_MAX=4, REP_DELAY=10, REP_PERIOD=5, ACTIVE_LOW=0. Hold btn_raw=1 from edge E0 -> level=1 and press_pulse=1 for one cycle at edge E0+5 (6th edge); level, press_pulse and rep_pulse=0 before that edge.
- Bounce: btn_raw toggles 1,0,1,0 at 2-cycle intervals, then held 0 -> level stays 0; no pulses.
- Hold pressed 30 cycles after press_pulse at cycle P -> rep_pulse at exactly P+10, P+15, P+20, P+25, P+30. Then release -> release_pulse 6 edges later; no further rep_pulse.
- Release timed so the accepted release coincides with P+15 -> release_pulse=1 and rep_pulse=0 on that edge.
- Assert rst mid-hold (state HOLD_REPEAT, level=1) -> all outputs 0 asynchronously. After deassert with btn still held: full debounce (6 edges), then a new press_pulse.
- ACTIVE_LOW=1, btn_raw idles 1 -> level=0, no pulses. Drive btn_raw=0 -> press_pulse after 6 edges.
